// File: rtl/mask_compaction_scheduler.sv
// mask_compaction_scheduler: sequences the prefix adder and emits set-bit indices of a mask word, LANES per beat.
module mask_compaction_scheduler #(
  parameter int LANES     = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mask_valid_i,
  output logic               mask_ready_o,
  input  logic [31:0]        mask_i,
  output logic [31:0]        adder_mask_o,
  input  logic [191:0]       adder_psum_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [LANES*5-1:0] out_idx_o,
  output logic [LANES-1:0]   out_lane_valid_o,
  output logic [5:0]         out_dst_base_o,
  output logic               out_last_o,
  output logic               word_done_o,
  output logic [5:0]         word_count_o
);
  localparam int LAT_W = ADDER_LAT > 1 ? $clog2(ADDER_LAT) : 1;
  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;
  state_e state_q, state_d;
  logic [31:0] mask_q, mask_d;
  logic [6:0] base_q, base_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [5:0] total;
  logic fire;
  assign total = adder_psum_i[191:186];
  assign fire = out_valid_o && out_ready_i;
  assign adder_mask_o = mask_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      base_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
    end
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    base_d         = base_q;
    lat_d          = lat_q;
    mask_ready_o   = state_q == IDLE;
    out_valid_o    = state_q == EMIT && total != 6'd0;
    out_last_o     = out_valid_o && (base_q + 7'(LANES) >= {1'b0, total});
    out_dst_base_o = out_valid_o ? base_q[5:0] : 6'd0;
    word_done_o    = state_q == EMIT && (total == 6'd0 || (fire && out_last_o));
    word_count_o   = word_done_o ? total : 6'd0;
    unique case (state_q)
      IDLE: if (mask_valid_i) begin
        mask_d  = mask_i;
        base_d  = '0;
        lat_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        state_d = lat_q == LAT_W'(ADDER_LAT - 1) ? EMIT : CALC;
        lat_d   = lat_q == LAT_W'(ADDER_LAT - 1) ? lat_q : lat_q + 1'b1;
      end
      EMIT: begin
        base_d  = fire ? base_q + 7'(LANES) : base_q;
        state_d = word_done_o ? IDLE : EMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Lane j carries the set bit whose inclusive prefix count equals base+j+1.
  always_comb begin
    out_lane_valid_o = '0;
    out_idx_o        = '0;
    for (int j = 0; j < LANES; j++) begin
      out_lane_valid_o[j] = out_valid_o && (base_q + 7'(j) < {1'b0, total});
      for (int i = 0; i < 32; i++)
        if (out_lane_valid_o[j] && mask_q[i] && {1'b0, adder_psum_i[i*6 +: 6]} == base_q + 7'(j + 1))
          out_idx_o[j*5 +: 5] = 5'(i);
    end
  end
endmodule
